// File: rtl/ssd_tdm_driver.sv
// ssd_tdm_driver: 4-digit common-anode TDM seven-segment driver with per-frame snapshot; define LEADING_ZERO_BLANK_EN to suppress leading zeros
module ssd_tdm_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic [3:0] dp_en,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);
  localparam int W = $clog2(REFRESH_DIV);
  logic [W-1:0] div_cnt;
  logic [1:0]   idx;
  logic [3:0]   sh [4];
  logic [3:0]   sh_dp;
  logic         wrap;
  logic         snap;
  logic [3:0]   cur;
  logic [6:0]   seg_nx;
  assign wrap = div_cnt == W'(REFRESH_DIV - 1);
  assign snap = wrap && idx == 2'd3;
  assign cur  = sh[idx];
`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lz;
  assign lz[3] = sh[3] == 4'd0;
  assign lz[2] = lz[3] && sh[2] == 4'd0;
  assign lz[1] = lz[2] && sh[1] == 4'd0;
  assign lz[0] = 1'b0;
`endif
  // Decode the shadow digit selected by the scan index; non-BCD codes show a dash
  always_comb begin
    case (cur)
      4'd0:    seg_nx = 7'h40;
      4'd1:    seg_nx = 7'h79;
      4'd2:    seg_nx = 7'h24;
      4'd3:    seg_nx = 7'h30;
      4'd4:    seg_nx = 7'h19;
      4'd5:    seg_nx = 7'h12;
      4'd6:    seg_nx = 7'h02;
      4'd7:    seg_nx = 7'h78;
      4'd8:    seg_nx = 7'h00;
      4'd9:    seg_nx = 7'h10;
      default: seg_nx = 7'h3F;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (lz[idx]) seg_nx = 7'h7F;
`endif
  end
  // Dwell counter, scan index and once-per-frame snapshot of the inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
      sh      <= '{default: '0};
      sh_dp   <= '0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) idx <= idx + 1'b1;
      if (snap) begin
        sh[0] <= ones;
        sh[1] <= tens;
        sh[2] <= hundreds;
        sh[3] <= thousands;
        sh_dp <= dp_en;
      end
    end
  end
  // Registered active-low outputs, one clock behind the scan index
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= blank ? 4'hF : ~(4'b0001 << idx);
      seg        <= blank ? 7'h7F : seg_nx;
      dp         <= blank | ~sh_dp[idx];
      frame_tick <= snap;
    end
  end
endmodule

// File: tb/tb_ssd_tdm_driver.sv
// tb_ssd_tdm_driver: scoreboard bench for ssd_tdm_driver at REFRESH_DIV=4
module tb_ssd_tdm_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ones = '0, tens = '0, hundreds = '0, thousands = '0, dp_en = '0;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;
  int         errors = 0;
  int         checks = 0;
  logic [12:0] q [$];
  logic [6:0] fseg [7][4];
  logic [3:0] fdp [7];
  localparam logic [12:0] RST_EXP = {4'hF, 7'h7F, 1'b1, 1'b0};

  always #5 clk = ~clk;

  ssd_tdm_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .ones(ones), .tens(tens), .hundreds(hundreds),
    .thousands(thousands), .dp_en(dp_en), .blank(blank), .seg(seg), .dp(dp),
    .an(an), .frame_tick(frame_tick)
  );

  // Expected outputs after the n-th edge since reset release; frame f uses table entry fb+f
  function automatic logic [12:0] exp_at(input int fb, input int n, input logic b);
    int f = fb + (n - 1) / 16;
    int d = ((n - 1) / 4) % 4;
    logic [3:0] a = ~(4'b0001 << d);
    logic ft = (n % 16) == 0;
    return b ? {4'hF, 7'h7F, 1'b1, ft} : {a, fseg[f][d], fdp[f][d], ft};
  endfunction

  // Monitor: every cycle the DUT presents a registered output; compare against the queue head
  always @(negedge clk) begin
    if (q.size() > 0) begin
      logic [12:0] e;
      e = q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++;
        $display("FAIL scan t=%0t: got an=%b seg=%h dp=%b ft=%b, exp an=%b seg=%h dp=%b ft=%b",
                 $time, an, seg, dp, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
  end

  initial begin
    fseg[0] = '{7'h40, 7'h40, 7'h40, 7'h40}; fdp[0] = 4'b1111;
    fseg[1] = '{7'h19, 7'h30, 7'h24, 7'h79}; fdp[1] = 4'b1111;
    fseg[2] = '{7'h3F, 7'h10, 7'h12, 7'h00}; fdp[2] = 4'b1011;
    fseg[3] = '{7'h3F, 7'h10, 7'h12, 7'h00}; fdp[3] = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
    fseg[4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F}; fdp[4] = 4'b1111;
    fseg[5] = '{7'h40, 7'h78, 7'h7F, 7'h7F}; fdp[5] = 4'b1111;
    fseg[6] = '{7'h40, 7'h7F, 7'h7F, 7'h7F}; fdp[6] = 4'b1111;
`else
    fseg[4] = '{7'h40, 7'h40, 7'h40, 7'h40}; fdp[4] = 4'b1111;
    fseg[5] = '{7'h40, 7'h78, 7'h40, 7'h40}; fdp[5] = 4'b1111;
    fseg[6] = '{7'h40, 7'h40, 7'h40, 7'h40}; fdp[6] = 4'b1111;
`endif
    repeat (3) begin
      @(posedge clk); #1;
      q.push_back(RST_EXP);
    end
    for (int n = 1; n <= 58; n++) begin
      if (n == 6)  {thousands, hundreds, tens, ones, dp_en} = {4'd1, 4'd2, 4'd3, 4'd4, 4'b0000};
      if (n == 20) {thousands, hundreds, tens, ones, dp_en} = {4'd8, 4'd5, 4'd9, 4'hC, 4'b0100};
      blank = (n >= 36 && n <= 45);
      rst = (n == 58);
      @(posedge clk); #1;
      q.push_back(n == 58 ? RST_EXP : exp_at(0, n, blank));
    end
    rst = 1'b0;
    for (int n = 1; n <= 48; n++) begin
      if (n == 3)  {thousands, hundreds, tens, ones, dp_en} = {4'd0, 4'd0, 4'd7, 4'd0, 4'b0000};
      if (n == 20) {thousands, hundreds, tens, ones, dp_en} = '0;
      @(posedge clk); #1;
      q.push_back(exp_at(4, n, 1'b0));
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, exp 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
